// File: rtl/deser_pkg.sv
// Shared definitions for the serial deserializer and the parallel-side consumers.
package deser_pkg;

  // Default word width for the serial lane.
  localparam int DESER_WIDTH = 8;

  // Word type for consumers of the default-width parallel bus.
  typedef logic [DESER_WIDTH-1:0] word_t;

  // Width of the bit counter. It is never narrower than one bit.
  function automatic int count_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/deser_hold_reg.sv
// One-word holding register with a valid flag.
// A load and a drain can happen at the same edge. In that case the new word
// replaces the drained one, and valid stays set.
module deser_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  // Word storage and valid tracking. Data keeps its value after a drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      if (load) begin
        data <= load_data;
      end
      if (load) begin
        valid <= 1'b1;
      end else if (drain) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver. It accepts one bit per bit_valid/bit_ready
// handshake and assembles WIDTH-bit words. Completed words are presented
// through a one-word holding stage on an out_valid/out_ready handshake.
//
// Handshake rule for both sides: a transfer happens on a rising clk edge
// where valid and ready are both high. A producer holds its valid/data
// stable until that transfer. Ready never depends on the same side's valid.
module serial_deserializer
  import deser_pkg::*;
#(
  parameter int WIDTH     = DESER_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             frame_start,
  output logic [WIDTH-1:0] output_bus,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_error
);

  localparam int             CW   = count_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    count;

  logic             accept;
  logic             drain;
  logic [CW-1:0]    eff_idx;
  logic [CW-1:0]    pos;
  logic             last_bit;
  logic             complete;
  logic [CW-1:0]    count_next;
  logic [WIDTH-1:0] word_next;

  // The final bit is refused only when the hold stage is full and not draining.
  // This means a completed word can never overwrite an undelivered one.
  assign bit_ready = !(out_valid && (count == LAST) && !out_ready);
  assign accept    = bit_valid && bit_ready;
  assign drain     = out_valid && out_ready;

  // Work out the slot for the incoming bit and the word as it will look after it.
  // A frame_start restarts the word, so the incoming bit becomes bit 0.
  always_comb begin
    eff_idx    = frame_start ? '0 : count;
    pos        = LSB_FIRST ? eff_idx : (LAST - eff_idx);
    word_next  = frame_start ? '0 : shift_reg;
    for (int i = 0; i < WIDTH; i++) begin
      if (CW'(i) == pos) begin
        word_next[i] = bit_in;
      end
    end
    last_bit   = (eff_idx == LAST);
    complete   = accept && last_bit;
    count_next = last_bit ? '0 : (eff_idx + CW'(1));
  end

  // Shift register, bit counter and sticky frame error.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg   <= '0;
      count       <= '0;
      frame_error <= 1'b0;
    end else if (accept) begin
      shift_reg <= last_bit ? '0 : word_next;
      count     <= count_next;
      if (frame_start && (count != '0)) begin
        frame_error <= 1'b1;
      end
    end
  end

  deser_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk       (clk),
    .reset     (reset),
    .load      (complete),
    .load_data (word_next),
    .drain     (drain),
    .data      (output_bus),
    .valid     (out_valid)
  );

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer. It uses an LSB-first instance and an
// MSB-first instance that share the same stimulus, and the two stay in
// lockstep because readiness does not depend on the data.
module tb_serial_deserializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       frame_start = 1'b0;
  logic       out_ready = 1'b0;

  logic       bit_ready, out_valid, frame_error;
  logic [7:0] output_bus;
  logic       bit_ready_m, out_valid_m, frame_error_m;
  logic [7:0] output_bus_m;

  int compared = 0;
  int mismatched = 0;
  int valid_seen = 0;

  // Clock generation: 10 ns period.
  always #5 clk = ~clk;

  serial_deserializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .frame_start(frame_start), .output_bus(output_bus),
    .out_valid(out_valid), .out_ready(out_ready), .frame_error(frame_error)
  );

  serial_deserializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready_m), .frame_start(frame_start), .output_bus(output_bus_m),
    .out_valid(out_valid_m), .out_ready(out_ready), .frame_error(frame_error_m)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one bit for one edge, then sample 1 ns after that edge.
  task automatic send_bit(input logic b, input logic fs);
    bit_valid   = 1'b1;
    bit_in      = b;
    frame_start = fs;
    tick();
    bit_valid   = 1'b0;
    frame_start = 1'b0;
    bit_in      = 1'b0;
    if (out_valid === 1'b1) valid_seen++;
  endtask

  // Send the low n bits of w, starting with w[0].
  task automatic send_bits(input logic [7:0] w, input int n, input logic fs_first);
    for (int i = 0; i < n; i++) begin
      send_bit(w[i], fs_first && (i == 0));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    compared++; if (output_bus !== 8'h00) begin mismatched++; $display("FAIL reset_output_bus: got %h expected 00", output_bus); end
    compared++; if (frame_error !== 1'b0) begin mismatched++; $display("FAIL reset_frame_error: got %b expected 0", frame_error); end
    compared++; if (bit_ready !== 1'b1) begin mismatched++; $display("FAIL reset_bit_ready: got %b expected 1", bit_ready); end
  endtask

  task automatic test_bit_order();
    logic s [8];
    s = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    out_ready  = 1'b1;
    valid_seen = 0;
    for (int i = 0; i < 7; i++) send_bit(s[i], 1'b0);
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL order_early_valid: got %b expected 0", out_valid); end
    send_bit(s[7], 1'b0);
    compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL order_valid: got %b expected 1", out_valid); end
    compared++; if (output_bus !== 8'h4D) begin mismatched++; $display("FAIL order_lsb_word: got %h expected 4d", output_bus); end
    compared++; if (output_bus_m !== 8'hB2) begin mismatched++; $display("FAIL order_msb_word: got %h expected b2", output_bus_m); end
    tick();
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL order_valid_one_cycle: got %b expected 0", out_valid); end
    compared++; if (output_bus !== 8'h4D) begin mismatched++; $display("FAIL order_bus_holds: got %h expected 4d", output_bus); end
    compared++; if (valid_seen !== 1) begin mismatched++; $display("FAIL order_valid_count: got %0d expected 1", valid_seen); end
  endtask

  task automatic test_backpressure();
    logic [7:0] w1, w2;
    w1 = 8'hA5;
    w2 = 8'h3C;
    out_ready = 1'b0;
    send_bits(w1, 8, 1'b0);
    compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL bp_first_valid: got %b expected 1", out_valid); end
    compared++; if (output_bus !== 8'hA5) begin mismatched++; $display("FAIL bp_first_word: got %h expected a5", output_bus); end
    send_bits(w2, 7, 1'b0);
    bit_valid = 1'b1;
    bit_in    = w2[7];
    #1;
    compared++; if (bit_ready !== 1'b0) begin mismatched++; $display("FAIL bp_stall_ready: got %b expected 0", bit_ready); end
    tick();
    compared++; if (output_bus !== 8'hA5) begin mismatched++; $display("FAIL bp_stall_word: got %h expected a5", output_bus); end
    compared++; if (bit_ready !== 1'b0) begin mismatched++; $display("FAIL bp_still_stalled: got %b expected 0", bit_ready); end
    out_ready = 1'b1;
    #1;
    compared++; if (bit_ready !== 1'b1) begin mismatched++; $display("FAIL bp_release_ready: got %b expected 1", bit_ready); end
    tick();
    bit_valid = 1'b0;
    out_ready = 1'b0;
    compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL bp_second_valid: got %b expected 1", out_valid); end
    compared++; if (output_bus !== 8'h3C) begin mismatched++; $display("FAIL bp_second_word: got %h expected 3c", output_bus); end
    out_ready = 1'b1;
    tick();
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL bp_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_frame_realign();
    logic [7:0] w;
    w = 8'h5A;
    out_ready  = 1'b1;
    valid_seen = 0;
    send_bits(8'h07, 3, 1'b0);
    compared++; if (frame_error !== 1'b0) begin mismatched++; $display("FAIL realign_no_error_yet: got %b expected 0", frame_error); end
    send_bits(w, 8, 1'b1);
    compared++; if (frame_error !== 1'b1) begin mismatched++; $display("FAIL realign_error: got %b expected 1", frame_error); end
    compared++; if (output_bus !== 8'h5A) begin mismatched++; $display("FAIL realign_word: got %h expected 5a", output_bus); end
    compared++; if (valid_seen !== 1) begin mismatched++; $display("FAIL realign_word_count: got %0d expected 1", valid_seen); end
    tick();
    compared++; if (frame_error !== 1'b1) begin mismatched++; $display("FAIL realign_sticky: got %b expected 1", frame_error); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] w;
    w = 8'h22;
    out_ready = 1'b0;
    send_bits(8'h11, 8, 1'b0);
    send_bits(w, 7, 1'b0);
    compared++; if (output_bus !== 8'h11) begin mismatched++; $display("FAIL simul_held_word: got %h expected 11", output_bus); end
    out_ready = 1'b1;
    send_bit(w[7], 1'b0);
    out_ready = 1'b0;
    compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL simul_valid_kept: got %b expected 1", out_valid); end
    compared++; if (output_bus !== 8'h22) begin mismatched++; $display("FAIL simul_new_word: got %h expected 22", output_bus); end
    out_ready = 1'b1;
    tick();
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL simul_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send_bits(8'h12, 8, 1'b0);
    send_bits(8'h1F, 5, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
    compared++; if (output_bus !== 8'h00) begin mismatched++; $display("FAIL rst_mid_bus: got %h expected 00", output_bus); end
    compared++; if (frame_error !== 1'b0) begin mismatched++; $display("FAIL rst_mid_error: got %b expected 0", frame_error); end
    compared++; if (bit_ready !== 1'b1) begin mismatched++; $display("FAIL rst_mid_ready: got %b expected 1", bit_ready); end
    out_ready = 1'b1;
    send_bits(8'hFF, 8, 1'b1);
    compared++; if (output_bus !== 8'hFF) begin mismatched++; $display("FAIL rst_mid_next_word: got %h expected ff", output_bus); end
    compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL rst_mid_next_valid: got %b expected 1", out_valid); end
    compared++; if (frame_error !== 1'b0) begin mismatched++; $display("FAIL rst_mid_benign_start: got %b expected 0", frame_error); end
    tick();
  endtask

  initial begin
    test_reset();
    test_bit_order();
    test_backpressure();
    test_frame_realign();
    test_simultaneous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
